scr_arbiter: RTL
================

Name: scr_arbiter

Overview:
- Shares the single-port scratch RAM (256 x 10, synchronous write, asynchronous read) between two requesters.
  - Port A: CPU datapath.
  - Port B: auxiliary master, e.g. debug/UART loader.
- Built-in clear engine overwrites every location with a constant.
- Sits between the requesters and the scratch RAM instance. It drives the RAM's address, write-enable and write data, and receives its read data.

Parameters:
ADDR_W, 8, address width; depth = 2**ADDR_W
DATA_W, 10, data width
MAX_WAIT, 4, consecutive denied cycles after which B gets forced priority (1..15)
CLR_VALUE, 0, value written by the clear engine

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
a_req  in  1  port A request, held until granted
a_we  in  1  port A write (1) / read (0)
a_addr  in  ADDR_W  port A address
a_wdata  in  DATA_W  port A write data
a_gnt  out  1  port A access performed this cycle
a_rdata  out  DATA_W  port A read data, valid when a_gnt & ~a_we
b_req, b_we, b_addr, b_wdata, b_gnt, b_rdata  same as port A, for port B
clr_start  in  1  pulse: start clear sweep
clr_busy  out  1  clear sweep in progress
clr_done  out  1  one-cycle pulse after last clear write
scr_addr  out  ADDR_W  to RAM address
scr_wr  out  1  to RAM write enable
scr_din  out  DATA_W  to RAM write data
scr_dout  in  DATA_W  from RAM asynchronous read data

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - All state updates on the rising edge of clk.
- Reset state:
  - FSM = ARB; clr_cnt = 0; wait_cnt = 0; clr_busy = 0; clr_done = 0.
  - No grant asserts in any cycle where rst = 1.
  - scr_wr = 0 while rst = 1.
- Exactly one RAM access per cycle. Grants are combinational in the access cycle:
  - Read data: a_rdata = b_rdata = scr_dout (combinational).
  - Write: the write commits at the rising edge ending the grant cycle.
- FSM states: ARB, CLEAR.
- ARB state:
  - clr_start = 1 has precedence over requests. That cycle grants nothing, scr_wr = 0, clr_cnt <= 0, next state CLEAR.
  - Otherwise, if only one request is present, it is granted.
  - If both requests are present: A is granted unless wait_cnt == MAX_WAIT, in which case B is granted.
  - The granted port's addr/we/wdata drive scr_addr/scr_wr/scr_din.
  - With no grant: scr_wr = 0, scr_addr = a_addr.
- wait_cnt:
  - Increments when b_req = 1 and B is not granted. Saturates at MAX_WAIT.
  - Clears to 0 when B is granted or b_req = 0.
- CLEAR state:
  - Each cycle: scr_wr = 1, scr_addr = clr_cnt, scr_din = CLR_VALUE; clr_cnt increments.
  - clr_busy = 1 throughout CLEAR.
  - a_gnt = b_gnt = 0 throughout; requests stall and stay held.
  - wait_cnt is held.
  - clr_start is ignored (no restart).
- Clear completion:
  - After the write at address 2**ADDR_W-1 (clr_cnt wraps to 0), next state is ARB.
  - clr_done pulses high for exactly the first ARB cycle.
  - A sweep takes exactly 2**ADDR_W cycles.
  - Arbitration resumes in the clr_done cycle.
- Reset mid-sweep:
  - Returns to ARB at the next edge; no clr_done pulse.
  - Locations not yet written keep their old contents.
- Other boundary rules:
  - Read and write to the same address by A then B in consecutive cycles: B sees the value A wrote.
  - A write and a read never happen in the same cycle.
  - The arbiter never grants both ports in one cycle.

Optional Feature:
- Macro: SCR_ARB_RR_EN.
- Defined:
  - Fixed priority and wait_cnt are removed. A 1-bit last-grant register is used instead (reset value: B, so A wins first).
  - On contention, the port not granted last wins.
  - The register updates only on actual grants.
  - MAX_WAIT is unused.
- Undefined:
  - Fixed A priority with MAX_WAIT starvation forcing, as described above.

Test Plan:
- Reset and idle:
  - Stimulus: rst held 2 cycles, then release with no requests.
  - Response: clr_busy = 0, clr_done = 0, a_gnt = b_gnt = 0, scr_wr = 0 every cycle.
- Single ports:
  - Stimulus: A writes 0x2A5 to addr 0x10, next cycle A reads 0x10; then B writes 0x0F3 to 0xFF and reads it back.
  - Response: a_rdata = 0x2A5 in A's read grant cycle; b_rdata = 0x0F3 in B's read grant cycle.
- Contention, MAX_WAIT = 4, macro undefined:
  - Stimulus: a_req and b_req held high continuously.
  - Response: grant pattern A,A,A,A,B repeating; no cycle has both grants.
- Clear sweep:
  - Stimulus: preload addr 0x00 = 0x3FF and 0x80 = 0x155, pulse clr_start, hold a_req high.
  - Response: clr_busy high for 256 cycles, a_gnt = 0 during the sweep, clr_done pulses once; A is granted in the clr_done cycle; both locations read back 0.
- Reset mid-sweep:
  - Stimulus: start a clear, assert rst at sweep cycle 100.
  - Response: no clr_done; addr 0x05 reads 0; addr 0xF0 keeps its preloaded 0x123.
- SCR_ARB_RR_EN defined:
  - Stimulus: both requests held high.
  - Response: grants alternate A,B,A,B starting with A after reset.

Source files
------------

// File: rtl/scr_arbiter.sv
// scr_arbiter: shares the single-port scratch RAM between ports A and B, with a built-in clear sweep.
// Define SCR_ARB_RR_EN for round-robin contention instead of fixed A priority with starvation forcing.
module scr_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 10,
  parameter int MAX_WAIT = 4,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] scr_addr,
  output logic              scr_wr,
  output logic [DATA_W-1:0] scr_din,
  input  logic [DATA_W-1:0] scr_dout
);

  // state | meaning
  // ARB   | arbitrate A/B requests, accept clr_start
  // CLEAR | write CLR_VALUE at clr_cnt every cycle, both ports stalled
  typedef enum logic {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              done_nxt;
  logic              b_first;

`ifdef SCR_ARB_RR_EN
  logic last_b;

  assign b_first = ~last_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (a_gnt || b_gnt) begin
      last_b <= b_gnt;
    end
  end
`else
  localparam int WAIT_W = 4;
  logic [WAIT_W-1:0] wait_cnt;

  assign b_first = (wait_cnt == WAIT_W'(MAX_WAIT));

  // Counter only moves in ARB; a sweep freezes B's accumulated starvation.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ST_ARB) begin
      if (b_req && !b_gnt) begin
        if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end
`endif

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    done_nxt    = 1'b0;
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    scr_wr      = 1'b0;
    scr_addr    = a_addr;
    scr_din     = a_wdata;
    case (state)
      ST_ARB: begin
        if (clr_start) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end else if (a_req && b_req) begin
          if (b_first) b_gnt = 1'b1;
          else         a_gnt = 1'b1;
        end else begin
          a_gnt = a_req;
          b_gnt = b_req;
        end
        if (b_gnt) begin
          scr_addr = b_addr;
          scr_wr   = b_we;
          scr_din  = b_wdata;
        end else if (a_gnt) begin
          scr_wr   = a_we;
        end
      end
      ST_CLEAR: begin
        scr_wr      = 1'b1;
        scr_addr    = clr_cnt;
        scr_din     = CLR_VALUE;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == {ADDR_W{1'b1}}) begin
          state_nxt = ST_ARB;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_ARB;
    endcase
    // Reset masks every side effect, including a half-finished sweep.
    if (rst) begin
      a_gnt  = 1'b0;
      b_gnt  = 1'b0;
      scr_wr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ARB;
      clr_cnt  <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_cnt  <= clr_cnt_nxt;
      clr_done <= done_nxt;
    end
  end

  assign clr_busy = (state == ST_CLEAR);
  assign a_rdata  = scr_dout;
  assign b_rdata  = scr_dout;

endmodule
